ptp_ts_arb_mux: RTL and testbench

// - Shares one timestamp return path between PORTS per-port PTP timestamp extractors.
// - Each port's extractor presents a timestamp with no backpressure. The block buffers it in a per-port FIFO.
// - A round-robin arbiter drains the FIFOs into one AXI-stream-style output carrying timestamp, tag and source port.
// - Sits between the per-port MAC timestamp extractors and the single host/DMA timestamp completion queue.

---
 rtl/ptp_ts_arb_mux.sv | 149 ++++++++++++++
 tb/tb_ptp_ts_arb_mux.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ptp_ts_arb_mux.sv
// Per-port timestamp FIFOs drained round-robin onto one valid/ready stream.
// Optional per-port saturating drop counters: define PTP_TS_ARB_MUX_DROP_CNT_EN.
module ptp_ts_arb_mux #(
    parameter int PORTS      = 4,
    parameter int TS_WIDTH   = 96,
    parameter int TAG_WIDTH  = 16,
    parameter int FIFO_DEPTH = 4,
    localparam int PW        = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PORTS*TS_WIDTH-1:0]  s_ts,
    input  logic [PORTS*TAG_WIDTH-1:0] s_ts_tag,
    input  logic [PORTS-1:0]           s_ts_valid,
    output logic [TS_WIDTH-1:0]        m_ts,
    output logic [TAG_WIDTH-1:0]       m_ts_tag,
    output logic [PW-1:0]              m_ts_port,
    output logic                       m_ts_valid,
    input  logic                       m_ts_ready,
    output logic [PORTS-1:0]           overflow,
`ifdef PTP_TS_ARB_MUX_DROP_CNT_EN
    output logic [PORTS-1:0]           fifo_nonempty,
    output logic [PORTS*16-1:0]        drop_count
`else
    output logic [PORTS-1:0]           fifo_nonempty
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = TS_WIDTH + TAG_WIDTH;
    localparam logic [AW:0]   DEPTH_W = (AW+1)'(FIFO_DEPTH);
    localparam logic [PW:0]   PORTS_W = (PW+1)'(PORTS);
    localparam logic [PW-1:0] LAST    = PW'(PORTS - 1);

    logic [DW-1:0]    mem [PORTS][FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr [PORTS];
    logic [AW-1:0]    rd_ptr [PORTS];
    logic [AW:0]      count [PORTS];
    logic [PORTS-1:0] nonempty, full, push, pop, drop;
    logic [PW-1:0]    rr_ptr, grant;
    logic [PW:0]      sum;
    logic             grant_found, load;

    assign load          = !m_ts_valid || m_ts_ready;
    assign fifo_nonempty = nonempty;

    always_comb begin
        for (int unsigned i = 0; i < PORTS; i++) begin
            nonempty[i] = (count[i] != '0);
            full[i]     = (count[i] == DEPTH_W);
        end
    end

    // First nonempty port at or after rr_ptr, wrapping at PORTS-1.
    always_comb begin
        grant_found = 1'b0;
        grant       = '0;
        sum         = '0;
        for (int unsigned k = 0; k < PORTS; k++) begin
            sum = {1'b0, rr_ptr} + (PW+1)'(k);
            if (sum >= PORTS_W)
                sum = sum - PORTS_W;
            if (!grant_found && nonempty[sum[PW-1:0]]) begin
                grant_found = 1'b1;
                grant       = sum[PW-1:0];
            end
        end
    end

    // A full FIFO still accepts a write when its head is popped the same cycle.
    always_comb begin
        for (int unsigned i = 0; i < PORTS; i++) begin
            pop[i]  = load && grant_found && (grant == PW'(i));
            push[i] = s_ts_valid[i] && (!full[i] || pop[i]);
            drop[i] = s_ts_valid[i] && full[i] && !pop[i];
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < PORTS; i++) begin
            if (push[i])
                mem[i][wr_ptr[i]] <= {s_ts[i*TS_WIDTH +: TS_WIDTH], s_ts_tag[i*TAG_WIDTH +: TAG_WIDTH]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < PORTS; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
            overflow <= '0;
        end else begin
            for (int unsigned i = 0; i < PORTS; i++) begin
                if (push[i])
                    wr_ptr[i] <= wr_ptr[i] + AW'(1);
                if (pop[i])
                    rd_ptr[i] <= rd_ptr[i] + AW'(1);
                if (push[i] && !pop[i])
                    count[i] <= count[i] + (AW+1)'(1);
                else if (!push[i] && pop[i])
                    count[i] <= count[i] - (AW+1)'(1);
            end
            overflow <= drop;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_ts       <= '0;
            m_ts_tag   <= '0;
            m_ts_port  <= '0;
            m_ts_valid <= 1'b0;
            rr_ptr     <= '0;
        end else if (load) begin
            if (grant_found) begin
                {m_ts, m_ts_tag} <= mem[grant][rd_ptr[grant]];
                m_ts_port        <= grant;
                m_ts_valid       <= 1'b1;
                rr_ptr           <= (grant == LAST) ? '0 : grant + PW'(1);
            end else begin
                m_ts_valid <= 1'b0;
            end
        end
    end

`ifdef PTP_TS_ARB_MUX_DROP_CNT_EN
    logic [15:0] drop_cnt [PORTS];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < PORTS; i++)
                drop_cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < PORTS; i++) begin
                if (drop[i] && drop_cnt[i] != '1)
                    drop_cnt[i] <= drop_cnt[i] + 16'd1;
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < PORTS; i++)
            drop_count[i*16 +: 16] = drop_cnt[i];
    end
`endif

endmodule

// File: tb/tb_ptp_ts_arb_mux.sv
// Bench for ptp_ts_arb_mux: directed vector table, corner sequences, random vs queue model.
module tb_ptp_ts_arb_mux;

    localparam int PORTS = 4;
    localparam int TSW   = 96;
    localparam int TAGW  = 16;
    localparam int DEPTH = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [PORTS*TSW-1:0]    s_ts;
    logic [PORTS*TAGW-1:0]   s_ts_tag;
    logic [PORTS-1:0]        s_ts_valid;
    logic [TSW-1:0]          m_ts;
    logic [TAGW-1:0]         m_ts_tag;
    logic [1:0]              m_ts_port;
    logic                    m_ts_valid;
    logic                    m_ts_ready;
    logic [PORTS-1:0]        overflow;
    logic [PORTS-1:0]        fifo_nonempty;
`ifdef PTP_TS_ARB_MUX_DROP_CNT_EN
    logic [PORTS*16-1:0]     drop_count;
`endif

    ptp_ts_arb_mux #(
        .PORTS(PORTS), .TS_WIDTH(TSW), .TAG_WIDTH(TAGW), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .s_ts(s_ts), .s_ts_tag(s_ts_tag), .s_ts_valid(s_ts_valid),
        .m_ts(m_ts), .m_ts_tag(m_ts_tag), .m_ts_port(m_ts_port),
        .m_ts_valid(m_ts_valid), .m_ts_ready(m_ts_ready),
        .overflow(overflow),
`ifdef PTP_TS_ARB_MUX_DROP_CNT_EN
        .fifo_nonempty(fifo_nonempty),
        .drop_count(drop_count)
`else
        .fifo_nonempty(fifo_nonempty)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: one queue per port, a single output slot, round-robin pointer.
    typedef logic [TSW+TAGW-1:0] ent_t;
    ent_t             q [PORTS][$];
    bit               mv;
    ent_t             mdata;
    int               mport;
    int               rr;
    logic [PORTS-1:0] movf;
    int               mdrop [PORTS];

    task automatic model_clock();
        if (rst) begin
            for (int i = 0; i < PORTS; i++) begin
                q[i].delete();
                mdrop[i] = 0;
            end
            mv = 0; mdata = '0; mport = 0; rr = 0; movf = '0;
        end else begin
            int g = -1;
            if (!mv || m_ts_ready) begin
                for (int k = 0; k < PORTS; k++)
                    if (g < 0 && q[(rr + k) % PORTS].size() > 0) g = (rr + k) % PORTS;
                if (g >= 0) begin
                    mdata = q[g].pop_front();
                    mport = g;
                    mv    = 1;
                    rr    = (g + 1) % PORTS;
                end else begin
                    mv = 0;
                end
            end
            for (int i = 0; i < PORTS; i++) begin
                movf[i] = 1'b0;
                if (s_ts_valid[i]) begin
                    if (q[i].size() >= DEPTH) begin
                        movf[i] = 1'b1;
                        if (mdrop[i] < 65535) mdrop[i]++;
                    end else begin
                        q[i].push_back({s_ts[i*TSW +: TSW], s_ts_tag[i*TAGW +: TAGW]});
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic check_model();
        logic [PORTS-1:0] ne;
        for (int i = 0; i < PORTS; i++) ne[i] = (q[i].size() > 0);
        chk("mdl_valid", m_ts_valid, mv);
        chk("mdl_overflow", overflow, movf);
        chk("mdl_nonempty", fifo_nonempty, ne);
        if (mv) begin
            chk("mdl_ts", m_ts, mdata[TAGW +: TSW]);
            chk("mdl_tag", m_ts_tag, mdata[TAGW-1:0]);
            chk("mdl_port", m_ts_port, mport);
        end
`ifdef PTP_TS_ARB_MUX_DROP_CNT_EN
        for (int i = 0; i < PORTS; i++)
            chk("mdl_drop_count", drop_count[i*16 +: 16], mdrop[i]);
`endif
    endtask

    task automatic drive(input logic r, input logic [3:0] v, input logic [95:0] tsb,
                         input logic [15:0] tagb, input logic rdy);
        rst = r;
        s_ts_valid = v;
        for (int i = 0; i < PORTS; i++) begin
            s_ts[i*TSW +: TSW]     = tsb + 96'(i);
            s_ts_tag[i*TAGW +: TAGW] = tagb + 16'(i);
        end
        m_ts_ready = rdy;
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  v;
        logic [95:0] ts;
        logic [15:0] tag;
        logic        rdy;
        logic        ev;
        logic [1:0]  eport;
        logic [95:0] ets;
        logic [15:0] etag;
        logic [3:0]  eovf;
        logic [3:0]  ene;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [95:0] ts,
                                input logic [15:0] tag, input logic rdy, input logic ev,
                                input logic [1:0] ep, input logic [95:0] ets,
                                input logic [15:0] etag, input logic [3:0] eovf,
                                input logic [3:0] ene);
        vec_t x;
        x.rst = r; x.v = v; x.ts = ts; x.tag = tag; x.rdy = rdy; x.ev = ev;
        x.eport = ep; x.ets = ets; x.etag = etag; x.eovf = eovf; x.ene = ene;
        return x;
    endfunction

    localparam int NV = 23;
    vec_t tbl [NV];

    initial begin
        // Port i is driven with ts = ts_base + i and tag = tag_base + i.
        tbl[0]  = mk(0, 4'b0100, 96'h1232, 16'h00A8, 1, 0, 0, 96'h0,    16'h0,    4'b0000, 4'b0100);
        tbl[1]  = mk(0, 4'b0000, 96'h0,    16'h0,    1, 1, 2, 96'h1234, 16'h00AA, 4'b0000, 4'b0000);
        tbl[2]  = mk(0, 4'b0000, 96'h0,    16'h0,    1, 0, 0, 96'h0,    16'h0,    4'b0000, 4'b0000);
        tbl[3]  = mk(1, 4'b0000, 96'h0,    16'h0,    1, 0, 0, 96'h0,    16'h0,    4'b0000, 4'b0000);
        tbl[4]  = mk(0, 4'b1111, 96'h1010, 16'h0010, 1, 0, 0, 96'h0,    16'h0,    4'b0000, 4'b1111);
        tbl[5]  = mk(0, 4'b0000, 96'h0,    16'h0,    1, 1, 0, 96'h1010, 16'h0010, 4'b0000, 4'b1110);
        tbl[6]  = mk(0, 4'b0000, 96'h0,    16'h0,    1, 1, 1, 96'h1011, 16'h0011, 4'b0000, 4'b1100);
        tbl[7]  = mk(0, 4'b0000, 96'h0,    16'h0,    1, 1, 2, 96'h1012, 16'h0012, 4'b0000, 4'b1000);
        tbl[8]  = mk(0, 4'b0000, 96'h0,    16'h0,    1, 1, 3, 96'h1013, 16'h0013, 4'b0000, 4'b0000);
        tbl[9]  = mk(0, 4'b0000, 96'h0,    16'h0,    1, 0, 0, 96'h0,    16'h0,    4'b0000, 4'b0000);
        tbl[10] = mk(0, 4'b0001, 96'h1030, 16'h0030, 0, 0, 0, 96'h0,    16'h0,    4'b0000, 4'b0001);
        tbl[11] = mk(0, 4'b0010, 96'h1020, 16'h0020, 0, 1, 0, 96'h1030, 16'h0030, 4'b0000, 4'b0010);
        tbl[12] = mk(0, 4'b0010, 96'h1021, 16'h0021, 0, 1, 0, 96'h1030, 16'h0030, 4'b0000, 4'b0010);
        tbl[13] = mk(0, 4'b0010, 96'h1022, 16'h0022, 0, 1, 0, 96'h1030, 16'h0030, 4'b0000, 4'b0010);
        tbl[14] = mk(0, 4'b0010, 96'h1023, 16'h0023, 0, 1, 0, 96'h1030, 16'h0030, 4'b0000, 4'b0010);
        tbl[15] = mk(0, 4'b0010, 96'h1024, 16'h0024, 0, 1, 0, 96'h1030, 16'h0030, 4'b0010, 4'b0010);
        tbl[16] = mk(0, 4'b0010, 96'h1025, 16'h0025, 0, 1, 0, 96'h1030, 16'h0030, 4'b0010, 4'b0010);
        tbl[17] = mk(0, 4'b0000, 96'h0,    16'h0,    0, 1, 0, 96'h1030, 16'h0030, 4'b0000, 4'b0010);
        tbl[18] = mk(0, 4'b0000, 96'h0,    16'h0,    1, 1, 1, 96'h1021, 16'h0021, 4'b0000, 4'b0010);
        tbl[19] = mk(0, 4'b0000, 96'h0,    16'h0,    1, 1, 1, 96'h1022, 16'h0022, 4'b0000, 4'b0010);
        tbl[20] = mk(0, 4'b0000, 96'h0,    16'h0,    1, 1, 1, 96'h1023, 16'h0023, 4'b0000, 4'b0010);
        tbl[21] = mk(0, 4'b0000, 96'h0,    16'h0,    1, 1, 1, 96'h1024, 16'h0024, 4'b0000, 4'b0000);
        tbl[22] = mk(0, 4'b0000, 96'h0,    16'h0,    1, 0, 0, 96'h0,    16'h0,    4'b0000, 4'b0000);

        // Reset state
        drive(1, 4'b0, 96'h0, 16'h0, 1'b0);
        tick();
        tick();
        chk("rst_valid", m_ts_valid, 1'b0);
        chk("rst_overflow", overflow, 4'b0);
        chk("rst_nonempty", fifo_nonempty, 4'b0);
        chk("rst_ts", m_ts, 96'h0);
        chk("rst_tag", m_ts_tag, 16'h0);
        chk("rst_port", m_ts_port, 2'd0);

        for (int k = 0; k < NV; k++) begin
            drive(tbl[k].rst, tbl[k].v, tbl[k].ts, tbl[k].tag, tbl[k].rdy);
            tick();
            chk("tbl_valid", m_ts_valid, tbl[k].ev);
            chk("tbl_overflow", overflow, tbl[k].eovf);
            chk("tbl_nonempty", fifo_nonempty, tbl[k].ene);
            if (tbl[k].ev) begin
                chk("tbl_port", m_ts_port, tbl[k].eport);
                chk("tbl_ts", m_ts, tbl[k].ets);
                chk("tbl_tag", m_ts_tag, tbl[k].etag);
            end
        end
`ifdef PTP_TS_ARB_MUX_DROP_CNT_EN
        chk("drop_count_p1", drop_count[16 +: 16], 16'd2);
        chk("drop_count_p0", drop_count[0 +: 16], 16'd0);
`endif

        // Full FIFO popped and written in the same cycle: no drop, new entry last.
        drive(1, 4'b0, 96'h0, 16'h0, 1'b0);
        tick();
        for (int k = 0; k < 5; k++) begin
            drive(0, 4'b0001, 96'h20A0 + 96'(k), 16'h00A0 + 16'(k), 1'b0);
            tick();
        end
        chk("full_pre_tag", m_ts_tag, 16'h00A0);
        drive(0, 4'b0001, 96'h20A5, 16'h00A5, 1'b1);
        tick();
        chk("full_same_cycle_ovf", overflow, 4'b0);
        chk("full_same_cycle_tag", m_ts_tag, 16'h00A1);
        for (int k = 2; k <= 5; k++) begin
            drive(0, 4'b0000, 96'h0, 16'h0, 1'b1);
            tick();
            chk("full_drain_valid", m_ts_valid, 1'b1);
            chk("full_drain_tag", m_ts_tag, 16'h00A0 + 16'(k));
            chk("full_drain_port", m_ts_port, 2'd0);
        end
        tick();
        chk("full_drain_end", m_ts_valid, 1'b0);

        // Reset while output valid and FIFOs hold data.
        drive(0, 4'b1111, 96'h30B0, 16'h00B0, 1'b0);
        tick();
        drive(0, 4'b0000, 96'h0, 16'h0, 1'b0);
        tick();
        chk("midrst_pre_valid", m_ts_valid, 1'b1);
        drive(1, 4'b0000, 96'h0, 16'h0, 1'b0);
        tick();
        chk("midrst_valid", m_ts_valid, 1'b0);
        chk("midrst_nonempty", fifo_nonempty, 4'b0);
        drive(0, 4'b0000, 96'h0, 16'h0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("midrst_no_stale", m_ts_valid, 1'b0);
        end
        drive(0, 4'b0100, 96'h40C0, 16'h00C0, 1'b1);
        tick();
        chk("midrst_lat1", m_ts_valid, 1'b0);
        drive(0, 4'b0000, 96'h0, 16'h0, 1'b1);
        tick();
        chk("midrst_lat2_valid", m_ts_valid, 1'b1);
        chk("midrst_lat2_tag", m_ts_tag, 16'h00C2);
        chk("midrst_lat2_port", m_ts_port, 2'd2);
        tick();
        chk("midrst_after", m_ts_valid, 1'b0);

        // Ready toggling with ports 0 and 3 streaming.
        for (int k = 0; k < 40; k++) begin
            drive(0, (k % 4 == 0) ? 4'b1001 : 4'b0000, 96'h5000 + 96'(k * 8),
                  16'h0100 + 16'(k * 8), (k % 2 == 1));
            tick();
            check_model();
            chk("toggle_no_ovf", overflow, 4'b0);
        end

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 299) == 0);
            for (int i = 0; i < PORTS; i++) begin
                s_ts_valid[i] = ($urandom_range(0, 2) == 0);
                s_ts[i*TSW +: TSW] = {$urandom, $urandom, $urandom};
                s_ts_tag[i*TAGW +: TAGW] = 16'($urandom);
            end
            m_ts_ready = (k % 500 < 250) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
            tick();
            check_model();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
